// File: rtl/mips_multicycle_cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, functs, FSM states,
// fault codes and ALU operation encoding.
package mips_multicycle_cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_t;

  typedef enum logic [1:0] {
    FaultNone    = 2'd0,
    FaultIllegal = 2'd1,
    FaultAlign   = 2'd2,
    FaultBus     = 2'd3
  } fault_t;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_t;

  // R-type funct to ALU operation; unsupported functs are trapped in decode.
  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FnSub:   return AluSub;
      FnAnd:   return AluAnd;
      FnOr:    return AluOr;
      FnSlt:   return AluSlt;
      default: return AluAdd;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OpRtype:                       return funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
      OpJ, OpBeq, OpAddi, OpLw, OpSw: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than.
module mips_mc_alu
  import mips_multicycle_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  // Pure combinational result select
  always_comb begin
    y = '0;
    unique case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluSlt:  y = {31'b0, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// FSM, instruction decode and architectural state (PC, IR, operand latches,
// retired counter, bus wait counter). Memory-side outputs are registered.
module mips_mc_control
  import mips_multicycle_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output alu_op_t          alu_op,
  input  logic [31:0]      alu_y
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  state_t            state;
  fault_t            fault_code;
  logic [31:0]       pc, ir, a, b, imm, alu_out, mdr, next_pc;
  logic [WaitW-1:0]  wait_cnt;
  logic [5:0]        opcode, funct;
  logic              legal, wait_last;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign legal     = is_legal(opcode, funct);
  assign wait_last = (wait_cnt == WaitW'(MAX_WAIT - 1));

  assign rs_addr  = ir[25:21];
  assign rt_addr  = ir[20:16];
  assign rf_we    = (state == StWb);
  assign rf_waddr = (opcode == OpRtype) ? ir[15:11] : ir[20:16];
  assign rf_wdata = (opcode == OpLw) ? mdr : alu_out;
  assign alu_a    = a;
  assign alu_b    = (opcode == OpRtype) ? b : imm;
  assign alu_op   = (opcode == OpRtype) ? funct_to_alu(funct) : AluAdd;
  assign fault    = fault_code;

  // Address of the next fetch; pc already holds PC+4 once the fetch completes
  always_comb begin
    next_pc = pc;
    if (state == StDecode && opcode == OpJ) begin
      next_pc = {pc[31:28], ir[25:0], 2'b00};
    end else if (state == StExec && opcode == OpBeq && a == b) begin
      next_pc = pc + {imm[29:0], 2'b00};
    end
  end

  // Main FSM; every retire re-arms the fetch request so FETCH costs one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StFetch;
      pc         <= RESET_PC;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      imm        <= '0;
      alu_out    <= '0;
      mdr        <= '0;
      wait_cnt   <= '0;
      retired    <= '0;
      fault_code <= FaultNone;
      halted     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      unique case (state)
        StFetch: begin
          if (!mem_req) begin
            // First cycle out of reset: raise the request one edge after release
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir       <= mem_rdata;
            pc       <= pc + 32'd4;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= StDecode;
          end else if (wait_last) begin
            mem_req    <= 1'b0;
            wait_cnt   <= '0;
            halted     <= 1'b1;
            fault_code <= FaultBus;
            state      <= StHalt;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StDecode: begin
          a   <= rs_data;
          b   <= rt_data;
          imm <= {{16{ir[15]}}, ir[15:0]};
          if (!legal) begin
            halted     <= 1'b1;
            fault_code <= FaultIllegal;
            state      <= StHalt;
          end else if (opcode == OpJ) begin
            pc       <= next_pc;
            mem_req  <= 1'b1;
            mem_addr <= next_pc;
            retired  <= retired + CNT_W'(1);
            state    <= StFetch;
          end else begin
            state <= StExec;
          end
        end
        StExec: begin
          alu_out <= alu_y;
          if (opcode == OpBeq) begin
            pc       <= next_pc;
            mem_req  <= 1'b1;
            mem_addr <= next_pc;
            retired  <= retired + CNT_W'(1);
            state    <= StFetch;
          end else if (opcode == OpLw || opcode == OpSw) begin
            if (alu_y[1:0] != 2'b00) begin
              halted     <= 1'b1;
              fault_code <= FaultAlign;
              state      <= StHalt;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= alu_y;
              mem_we    <= (opcode == OpSw);
              mem_wdata <= b;
              mem_be    <= (opcode == OpSw) ? 4'hF : 4'h0;
              state     <= StMem;
            end
          end else begin
            state <= StWb;
          end
        end
        StMem: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'h0;
            if (mem_we) begin
              mem_req  <= 1'b1;
              mem_addr <= next_pc;
              retired  <= retired + CNT_W'(1);
              state    <= StFetch;
            end else begin
              mdr   <= mem_rdata;
              state <= StWb;
            end
          end else if (wait_last) begin
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            halted     <= 1'b1;
            fault_code <= FaultBus;
            state      <= StHalt;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StWb: begin
          mem_req  <= 1'b1;
          mem_addr <= next_pc;
          retired  <= retired + CNT_W'(1);
          state    <= StFetch;
        end
        StHalt: begin
          state <= StHalt;
        end
        default: begin
          state <= StHalt;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_regfile.sv
// 32x32 register file, two async read ports, one sync write port; $0 is never written.
module mips_mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // Clear everything on reset; drop writes aimed at $0 so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS subset core: control FSM plus shared ALU and register file.
module mips_multicycle_cpu
  import mips_multicycle_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  logic [4:0]  rs_addr, rt_addr, rf_waddr;
  logic [31:0] rs_data, rt_data, rf_wdata;
  logic        rf_we;
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;

  mips_mc_control #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_control (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y)
  );

  mips_mc_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  mips_mc_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: small programs run against a bench-side
// memory; results are observed through stores, retire timing and fault outputs.
module tb_mips_multicycle_cpu;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retired;
  logic [3:0]  mem_be;
  logic [1:0]  fault;

  mips_multicycle_cpu #(
    .RESET_PC (RstPc),
    .CNT_W    (32),
    .MAX_WAIT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Memory: program image plus a store overlay; wait states apply to 0x80 and up
  logic [31:0] prog [64];
  logic [31:0] dmem [64];
  logic [63:0] written;
  int unsigned nwait = 0;
  logic        stall_all = 1'b0, stall_data = 1'b0;
  int unsigned wcnt;
  logic [3:0]  first_be, rd_be;
  int          st_cnt;
  logic        unstable, bad_align, hold_v;
  logic [31:0] hold_addr, hold_wd;
  logic [5:0]  idx;
  logic        data_acc;

  assign idx       = mem_addr[7:2];
  assign data_acc  = (mem_addr >= 32'h80);
  assign mem_rdata = written[idx] ? dmem[idx] : prog[idx];
  assign mem_ready = mem_req && !stall_all && !(stall_data && data_acc) &&
                     (!data_acc || wcnt >= nwait);

  always @(posedge clk) begin
    if (!rst) begin
      written   <= '0;
      wcnt      <= 0;
      first_be  <= 4'h0;
      rd_be     <= 4'hA;
      st_cnt    <= 0;
      unstable  <= 1'b0;
      bad_align <= 1'b0;
      hold_v    <= 1'b0;
    end else begin
      if (mem_req && mem_ready) begin
        wcnt   <= 0;
        hold_v <= 1'b0;
        if (mem_we) begin
          dmem[idx]    <= mem_wdata;
          written[idx] <= 1'b1;
          if (st_cnt == 0) first_be <= mem_be;
          st_cnt <= st_cnt + 1;
        end else if (data_acc) begin
          rd_be <= mem_be;
        end
      end else if (mem_req) begin
        wcnt      <= wcnt + 1;
        hold_v    <= 1'b1;
        hold_addr <= mem_addr;
        hold_wd   <= mem_wdata;
      end
      if (hold_v && mem_req && (mem_addr != hold_addr || mem_wdata != hold_wd)) unstable <= 1'b1;
      if (mem_req && mem_addr[1:0] != 2'b00) bad_align <= 1'b1;
    end
  end

  int total = 0, bad = 0;
  int cyc = 0, last_evt = 0, n_lat = 0;
  logic [31:0] prev_ret;
  int lat [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rd_word(input int i);
    return written[i] ? dmem[i] : prog[i];
  endfunction

  // One clock; logs the cycle distance between successive retires
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (retired != prev_ret) begin
      if (n_lat < 64) lat[n_lat] = cyc - last_evt;
      n_lat++;
      last_evt = cyc;
      prev_ret = retired;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'hDEAD_BEEF;
  endtask

  task automatic hold_reset(input int unsigned w, input logic sa, input logic sd);
    rst        = 1'b0;
    nwait      = w;
    stall_all  = sa;
    stall_data = sd;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("req_before_edge", mem_req, 1'b0);
    tick();
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, RstPc);
    for (int i = 0; i < 64; i++) lat[i] = 0;
    n_lat    = 0;
    last_evt = cyc;
    prev_ret = 32'd0;
  endtask

  task automatic run_until_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && !halted; i++) tick();
    check("halt_reached", halted, 1'b1);
  endtask

  initial begin
    logic seen_req;

    // Program 1: ALU ops, $0 write, untaken beq, stores, jump, illegal opcode
    clear_prog();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    prog[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
    prog[3]  = enc_r(6'h22, 5'd1, 5'd2, 5'd4);
    prog[4]  = enc_r(6'h2A, 5'd4, 5'd1, 5'd5);
    prog[5]  = enc_r(6'h25, 5'd1, 5'd2, 5'd6);
    prog[6]  = enc_r(6'h24, 5'd1, 5'd2, 5'd7);
    prog[7]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    prog[8]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    prog[9]  = enc_r(6'h2A, 5'd1, 5'd4, 5'd8);
    prog[10] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
    prog[11] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0084);
    prog[12] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0088);
    prog[13] = enc_i(6'h2B, 5'd0, 5'd6, 16'h008C);
    prog[14] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0090);
    prog[15] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0094);
    prog[16] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0098);
    prog[17] = {6'h02, 26'd20};
    prog[18] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
    prog[19] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
    prog[20] = enc_i(6'h2B, 5'd0, 5'd9, 16'h009C);
    prog[21] = 32'hFC00_0000;
    hold_reset(0, 1'b0, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be", mem_be, 4'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 2'd0);
    check("rst_retired", retired, 32'd0);
    release_reset();
    repeat (12) tick();
    check("three_after_12", retired, 32'd3);
    run_until_halt(600);
    check("p1_fault", fault, 2'd1);
    check("p1_retired", retired, 32'd19);
    check("p1_add", rd_word(32), 32'd12);
    check("p1_sub", rd_word(33), 32'hFFFF_FFFE);
    check("p1_slt_true", rd_word(34), 32'd1);
    check("p1_or", rd_word(35), 32'd7);
    check("p1_and", rd_word(36), 32'd5);
    check("p1_r0", rd_word(37), 32'd0);
    check("p1_slt_false", rd_word(38), 32'd0);
    check("p1_j_skip", rd_word(39), 32'd0);
    check("p1_sw_be", first_be, 4'hF);
    check("p1_lat_addi", lat[0], 4);
    check("p1_lat_add", lat[2], 4);
    check("p1_lat_beq", lat[8], 3);
    check("p1_lat_sw", lat[10], 4);
    check("p1_lat_j", lat[17], 2);

    // Illegal opcode at 0x8: halt is absorbing and the bus stays idle
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    prog[2] = 32'hFC00_0000;
    hold_reset(0, 1'b0, 1'b0);
    release_reset();
    run_until_halt(100);
    check("ill_fault", fault, 2'd1);
    check("ill_retired", retired, 32'd2);
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_req = seen_req | mem_req;
    end
    check("ill_req_idle", seen_req, 1'b0);
    check("ill_still_halted", halted, 1'b1);
    check("ill_retired_hold", retired, 32'd2);

    // Store then load with two data wait states
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
    prog[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0080);
    prog[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0084);
    prog[4] = 32'hFC00_0000;
    hold_reset(2, 1'b0, 1'b0);
    release_reset();
    run_until_halt(200);
    check("ls_sw_be", first_be, 4'hF);
    check("ls_lw_be", rd_be, 4'h0);
    check("ls_lw_data", rd_word(33), 32'd12);
    check("ls_lat_sw", lat[1], 6);
    check("ls_lat_lw", lat[2], 7);
    check("ls_retired", retired, 32'd4);
    check("ls_stable", unstable, 1'b0);

    // beq-to-self loop
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    hold_reset(0, 1'b0, 1'b0);
    release_reset();
    repeat (19) tick();
    check("loop_retired", retired, 32'd6);
    check("loop_lat1", lat[1], 3);
    check("loop_lat2", lat[2], 3);
    check("loop_lat5", lat[5], 3);
    check("loop_req", mem_req, 1'b1);
    check("loop_pc", mem_addr, 32'h4);

    // Misaligned load
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd2);
    prog[1] = enc_i(6'h23, 5'd1, 5'd2, 16'd0);
    hold_reset(0, 1'b0, 1'b0);
    release_reset();
    run_until_halt(100);
    check("mis_fault", fault, 2'd2);
    check("mis_retired", retired, 32'd1);
    check("mis_no_req", bad_align, 1'b0);

    // Bus timeout on the very first fetch
    clear_prog();
    hold_reset(0, 1'b1, 1'b0);
    release_reset();
    repeat (15) tick();
    check("to_early", fault, 2'd0);
    tick();
    check("to_fault", fault, 2'd3);
    check("to_halted", halted, 1'b1);
    check("to_req", mem_req, 1'b0);

    // Reset during a stalled store
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
    hold_reset(0, 1'b0, 1'b1);
    release_reset();
    for (int i = 0; i < 50 && !(mem_req && mem_we); i++) tick();
    check("rm_store_seen", mem_req & mem_we, 1'b1);
    check("rm_retired_pre", retired, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_req_async", mem_req, 1'b0);
    check("rm_retired_async", retired, 32'd0);
    release_reset();
    check("rm_retired_post", retired, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_cpu.md
MIPS_MULTICYCLE_CPU -- requirements
Module: mips_multicycle_cpu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 The block SHALL have parameter MAX_WAIT, default 16, meaning the number of mem_ready-low cycles tolerated before a bus fault.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port mem_req, output, 1 bit: memory access request.
REQ-007 The block SHALL have port mem_we, output, 1 bit: the request is a write.
REQ-008 The block SHALL have port mem_addr, output, 32 bits: the word-aligned byte address.
REQ-009 The block SHALL have port mem_wdata, output, 32 bits: the store data.
REQ-010 The block SHALL have port mem_be, output, 4 bits: the byte enables; 4'hF for sw, 4'h0 for reads.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: the read data, valid in the cycle mem_ready=1.
REQ-012 The block SHALL have port mem_ready, input, 1 bit: access completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-013 The block SHALL have port halted, output, 1 bit: the core is in HALT.
REQ-014 The block SHALL have port fault, output, 2 bits: 0=none, 1=illegal opcode, 2=misaligned, 3=bus timeout.
REQ-015 The block SHALL have port retired, output, CNT_W bits: the count of completed instructions.

Function
REQ-016 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT, with one state per cycle except where a memory wait holds it.
REQ-017 In FETCH, the block SHALL drive mem_req=1 and mem_addr=PC; on mem_ready it SHALL latch IR, set PC+=4 and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-018 In DECODE, the block SHALL latch register operands A=rs and B=rt, plus the sign-extended immediate.
REQ-019 For j in DECODE, the block SHALL set PC={PC[31:28],target,2'b00}, retire the instruction and go to FETCH.
REQ-020 In EXEC, the block SHALL compute ALU results with 32-bit wrap and no overflow trap: add/sub/and/or/slt (signed) for R-type, addi, and base+offset for lw/sw.
REQ-021 For beq in EXEC, if A==B the block SHALL set PC=PC+(imm<<2); it SHALL then retire the instruction and go to FETCH.
REQ-022 In MEM, the block SHALL hold mem_req, mem_addr, mem_we, mem_wdata and mem_be stable until mem_ready.
REQ-023 When sw completes in MEM, the block SHALL retire the instruction and go to FETCH.
REQ-024 When lw completes in MEM, the block SHALL latch mem_rdata and go to WB.
REQ-025 In WB, the block SHALL write rd (R-type) or rt (addi/lw), retire the instruction and go to FETCH.
REQ-026 Writes to register 0 SHALL be suppressed, so that $0 always reads 0.
REQ-027 Latency with zero wait states SHALL be: j 2, beq 3, sw 4, R-type/addi 4, lw 5 cycles; each wait cycle SHALL add one cycle.
REQ-028 Any opcode or funct outside the supported set SHALL cause a transition to HALT with fault=1.
REQ-029 An lw/sw effective address with addr[1:0]!=0 SHALL cause a transition to HALT with fault=2, without asserting mem_req.
REQ-030 After MAX_WAIT consecutive cycles with mem_req=1 and mem_ready=0, the block SHALL transition to HALT with fault=3.
REQ-031 The wait counter SHALL clear on every completed access.
REQ-032 HALT SHALL be absorbing until reset, with mem_req=0 and halted=1.
REQ-033 The retired counter SHALL wrap from all-ones to 0.
REQ-034 A faulting instruction SHALL NOT be counted as retired.
REQ-035 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.

Reset
REQ-036 On rst=0, the block SHALL immediately and asynchronously force state=FETCH, PC=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, halted=0, fault=0, retired=0, all registers=0 and IR=0.
REQ-037 A reset asserted mid-access SHALL abandon that access; after release, the first request SHALL be a fetch from RESET_PC.
REQ-038 mem_req SHALL assert no earlier than the first rising edge after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the opcode/funct constants, the FSM state enum, the fault codes and the ALU op encoding.
REQ-040 The ALU and the 32x32 register file SHALL be instantiated as sub-modules and reused.
REQ-041 The FSM plus instruction decode SHALL form one sub-module, mips_mc_control.

Verification
REQ-042 Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2, run with mem_ready tied to 1 -> $3=12, retired=3 after 12 cycles.
REQ-043 sw $3,0($0) followed by lw $4,0($0), with 2 wait states per access -> mem_be=4'hF on the store, $4=12, lw takes 7 cycles.
REQ-044 beq $1,$1,-1 loop -> PC returns to the beq address every 3 cycles; retired increments by 1 per pass.
REQ-045 Opcode 6'h3F at PC 0x8 -> halted=1, fault=1, retired unchanged, mem_req stays 0.
REQ-046 lw at address 0x2 -> fault=2; separately, mem_ready held at 0 -> fault=3 after 16 wait cycles.
REQ-047 rst asserted low during a stalled MEM access -> mem_req drops in the same cycle; after release, mem_addr=RESET_PC and retired=0.
